// File: rtl/hazard_pkg.sv
// ============================================================================
// hazard_pkg : shared types and constants for the pipeline hazard controller
// Rev 1.0
// ============================================================================
`default_nettype none

package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LD_STALL = 2'd1,
    MC_BUSY  = 2'd2
  } hz_state_e;

  localparam int RESOLVE_EX  = 1;
  localparam int RESOLVE_MEM = 2;

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// ============================================================================
// sat_counter : increment-by-one counter that holds at all-ones
// Rev 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl_unit.sv
// ============================================================================
// hazard_ctrl_unit : load-use stall, multi-cycle EX freeze and redirect flush
// control for the 5-stage pipeline, with saturating stall/flush counters
// Rev 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_W         = 5,
  parameter int LOAD_STALL    = 1,
  parameter int MC_LATENCY    = 4,
  parameter int RESOLVE_STAGE = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             EX_mem_read_i,
  input  logic [REG_W-1:0] EX_reg_rt_i,
  input  logic [REG_W-1:0] ID_reg_rs_i,
  input  logic [REG_W-1:0] ID_reg_rt_i,
  input  logic             EX_mc_start_i,
  input  logic             redirect_i,
  output logic             pc_write_o,
  output logic             IF_ID_write_o,
  output logic             ID_EX_write_o,
  output logic             stall_o,
  output logic             EX_MEM_bubble_o,
  output logic             IF_ID_flush_o,
  output logic             ID_EX_flush_o,
  output logic             EX_MEM_flush_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] stall_count_o,
  output logic [CNT_W-1:0] flush_count_o
);

  if (LOAD_STALL < 1 || LOAD_STALL > 15) begin : g_chk_load_stall
    $error("hazard_ctrl_unit: LOAD_STALL must be in 1..15");
  end
  if (MC_LATENCY < 1 || MC_LATENCY > 15) begin : g_chk_mc_latency
    $error("hazard_ctrl_unit: MC_LATENCY must be in 1..15");
  end
  if (RESOLVE_STAGE != RESOLVE_EX && RESOLVE_STAGE != RESOLVE_MEM) begin : g_chk_resolve
    $error("hazard_ctrl_unit: RESOLVE_STAGE must be 1 (EX) or 2 (MEM)");
  end

  // Cycles still owed after the first stall/freeze cycle, minus one (rem==0 is the last)
  localparam logic [3:0] LD_REM = 4'((LOAD_STALL > 1) ? (LOAD_STALL - 2) : 0);
  localparam logic [3:0] MC_REM = 4'((MC_LATENCY > 1) ? (MC_LATENCY - 2) : 0);
  localparam logic       FLUSH_EX_MEM = (RESOLVE_STAGE == RESOLVE_MEM);

  hz_state_e  state_q, state_d;
  logic [3:0] rem_q, rem_d;
  logic       hazard;

  assign hazard = EX_mem_read_i && (EX_reg_rt_i != '0) &&
                  ((EX_reg_rt_i == ID_reg_rs_i) || (EX_reg_rt_i == ID_reg_rt_i));

  always_comb begin
    state_d         = state_q;
    rem_d           = rem_q;
    pc_write_o      = 1'b1;
    IF_ID_write_o   = 1'b1;
    ID_EX_write_o   = 1'b1;
    stall_o         = 1'b0;
    EX_MEM_bubble_o = 1'b0;
    IF_ID_flush_o   = 1'b0;
    ID_EX_flush_o   = 1'b0;
    EX_MEM_flush_o  = 1'b0;
    busy_o          = 1'b0;

    if (redirect_i) begin
      // Anything frozen behind a taken redirect is wrong-path, so abandon it
      IF_ID_flush_o  = 1'b1;
      ID_EX_flush_o  = 1'b1;
      EX_MEM_flush_o = FLUSH_EX_MEM;
      state_d        = IDLE;
      rem_d          = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (EX_mc_start_i) begin
            pc_write_o      = 1'b0;
            IF_ID_write_o   = 1'b0;
            ID_EX_write_o   = 1'b0;
            EX_MEM_bubble_o = 1'b1;
            busy_o          = 1'b1;
            if (MC_LATENCY > 1) begin
              state_d = MC_BUSY;
              rem_d   = MC_REM;
            end
          end else if (hazard) begin
            pc_write_o    = 1'b0;
            IF_ID_write_o = 1'b0;
            stall_o       = 1'b1;
            if (LOAD_STALL > 1) begin
              state_d = LD_STALL;
              rem_d   = LD_REM;
            end
          end
        end
        LD_STALL: begin
          pc_write_o    = 1'b0;
          IF_ID_write_o = 1'b0;
          stall_o       = 1'b1;
          if (rem_q == 4'd0) state_d = IDLE;
          else               rem_d   = rem_q - 4'd1;
        end
        MC_BUSY: begin
          pc_write_o      = 1'b0;
          IF_ID_write_o   = 1'b0;
          ID_EX_write_o   = 1'b0;
          EX_MEM_bubble_o = 1'b1;
          busy_o          = 1'b1;
          if (rem_q == 4'd0) state_d = IDLE;
          else               rem_d   = rem_q - 4'd1;
        end
        default: begin
          state_d = IDLE;
          rem_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (~pc_write_o),
    .count_o (stall_count_o)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (redirect_i),
    .count_o (flush_count_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench: two hazard_ctrl_unit configurations share one stimulus stream;
// a reference model predicts per-cycle outputs which a monitor checks at negedge.
`default_nettype none

module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mem_read = 1'b0;
  logic [4:0] ex_rt = '0, id_rs = '0, id_rt = '0;
  logic       mc_start = 1'b0;
  logic       redirect = 1'b0;

  always #5 clk = ~clk;

  logic       a_pc, a_ifid, a_idex, a_stall, a_bub, a_iff, a_idf, a_exf, a_busy;
  logic [3:0] a_sc, a_fc;
  logic       b_pc, b_ifid, b_idex, b_stall, b_bub, b_iff, b_idf, b_exf, b_busy;
  logic [7:0] b_sc, b_fc;

  // A: LOAD_STALL=3, MC_LATENCY=4, resolve in MEM, 4-bit counters
  hazard_ctrl_unit #(.REG_W(5), .LOAD_STALL(3), .MC_LATENCY(4), .RESOLVE_STAGE(2), .CNT_W(4)) u_a (
    .clk(clk), .rst_n(rst_n), .EX_mem_read_i(mem_read), .EX_reg_rt_i(ex_rt),
    .ID_reg_rs_i(id_rs), .ID_reg_rt_i(id_rt), .EX_mc_start_i(mc_start), .redirect_i(redirect),
    .pc_write_o(a_pc), .IF_ID_write_o(a_ifid), .ID_EX_write_o(a_idex), .stall_o(a_stall),
    .EX_MEM_bubble_o(a_bub), .IF_ID_flush_o(a_iff), .ID_EX_flush_o(a_idf), .EX_MEM_flush_o(a_exf),
    .busy_o(a_busy), .stall_count_o(a_sc), .flush_count_o(a_fc));

  // B: single-cycle load stall and MC op, resolve in EX, 8-bit counters
  hazard_ctrl_unit #(.REG_W(5), .LOAD_STALL(1), .MC_LATENCY(1), .RESOLVE_STAGE(1), .CNT_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .EX_mem_read_i(mem_read), .EX_reg_rt_i(ex_rt),
    .ID_reg_rs_i(id_rs), .ID_reg_rt_i(id_rt), .EX_mc_start_i(mc_start), .redirect_i(redirect),
    .pc_write_o(b_pc), .IF_ID_write_o(b_ifid), .ID_EX_write_o(b_idex), .stall_o(b_stall),
    .EX_MEM_bubble_o(b_bub), .IF_ID_flush_o(b_iff), .ID_EX_flush_o(b_idf), .EX_MEM_flush_o(b_exf),
    .busy_o(b_busy), .stall_count_o(b_sc), .flush_count_o(b_fc));

  // Flag order: pc, IF_ID_w, ID_EX_w, stall, bubble, IF_ID_fl, ID_EX_fl, EX_MEM_fl, busy
  logic [8:0] fa, fb;
  assign fa = {a_pc, a_ifid, a_idex, a_stall, a_bub, a_iff, a_idf, a_exf, a_busy};
  assign fb = {b_pc, b_ifid, b_idex, b_stall, b_bub, b_iff, b_idf, b_exf, b_busy};

  typedef struct {
    logic [8:0] fa;
    logic [8:0] fb;
    int         sca, fca, scb, fcb;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: "left" = frozen cycles still owed after the current one
  int left_a = 0, left_b = 0;
  bit mc_a = 0, mc_b = 0;
  int sc_a = 0, fc_a = 0, sc_b = 0, fc_b = 0;

  task automatic model_step(inout int left, inout bit mc, inout int sc, inout int fc,
                            input int ls, input int mcl, input int rs_stage, input int cmax,
                            output logic [8:0] f, output int sc_now, output int fc_now);
    bit hz;
    hz = mem_read && (ex_rt != 5'd0) && (ex_rt == id_rs || ex_rt == id_rt);
    sc_now = sc;
    fc_now = fc;
    if (redirect) begin
      f = {3'b111, 2'b00, 1'b1, 1'b1, (rs_stage == 2), 1'b0};
      left = 0;
    end else if (left > 0) begin
      f = mc ? 9'b000_0_1_000_1 : 9'b001_1_0_000_0;
      left = left - 1;
    end else if (mc_start) begin
      f = 9'b000_0_1_000_1;
      mc = 1;
      left = mcl - 1;
    end else if (hz) begin
      f = 9'b001_1_0_000_0;
      mc = 0;
      left = ls - 1;
    end else begin
      f = 9'b111_0_0_000_0;
    end
    if (!f[8] && sc < cmax) sc = sc + 1;
    if (redirect && fc < cmax) fc = fc + 1;
  endtask

  task automatic push_expected();
    exp_t e;
    model_step(left_a, mc_a, sc_a, fc_a, 3, 4, 2, 15,  e.fa, e.sca, e.fca);
    model_step(left_b, mc_b, sc_b, fc_b, 1, 1, 1, 255, e.fb, e.scb, e.fcb);
    q.push_back(e);
  endtask

  task automatic drive(input logic rd, input logic [4:0] rt, input logic [4:0] rs,
                       input logic [4:0] rtid, input logic mcs, input logic rdr);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_read = rd; ex_rt = rt; id_rs = rs; id_rt = rtid; mc_start = mcs; redirect = rdr;
    push_expected();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  // Asserts reset away from the clock edge; outputs must go idle and counters clear at once
  task automatic reset_cycle();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    mem_read = 1'b0; ex_rt = '0; id_rs = '0; id_rt = '0; mc_start = 1'b0; redirect = 1'b0;
    left_a = 0; left_b = 0; sc_a = 0; fc_a = 0; sc_b = 0; fc_b = 0;
    push_expected();
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s @%0t actual=0x%0h expected=0x%0h", name, $time, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("flags_a", int'(fa), int'(e.fa));
      chk("flags_b", int'(fb), int'(e.fb));
      chk("stall_cnt_a", int'(a_sc), e.sca);
      chk("flush_cnt_a", int'(a_fc), e.fca);
      chk("stall_cnt_b", int'(b_sc), e.scb);
      chk("flush_cnt_b", int'(b_fc), e.fcb);
    end
  end

  initial begin
    reset_cycle();
    idle(2);
    // Load-use on rs: A stalls 3 cycles, B one
    drive(1'b1, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0);
    idle(4);
    // Load into r0 never stalls
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    idle(1);
    // Multi-cycle op
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    idle(5);
    // Redirect on second MC_BUSY cycle
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    idle(2);
    // Redirect together with hazard / with MC start
    drive(1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b1);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    idle(2);
    // Hazard held: back-to-back sequences, then counter saturation
    for (int i = 0; i < 20; i++) drive(1'b1, 5'd9, 5'd2, 5'd9, 1'b0, 1'b0);
    idle(2);
    // Reset in the middle of LD_STALL
    drive(1'b1, 5'd4, 5'd4, 5'd4, 1'b0, 1'b0);
    reset_cycle();
    idle(2);
    // Randomised traffic from a small register pool so matches are frequent
    for (int i = 0; i < 600; i++) begin
      logic [4:0] pool [4];
      pool[0] = 5'd0; pool[1] = 5'd1; pool[2] = 5'd8; pool[3] = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 99) == 0) begin
        reset_cycle();
      end else begin
        drive(($urandom_range(0, 2) == 0),
              pool[$urandom_range(0, 3)], pool[$urandom_range(0, 3)], pool[$urandom_range(0, 3)],
              ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0));
      end
    end
    idle(1);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
